n_clic_ext_irq: RTL and testbench
=================================

// Module: n_clic_ext_irq
// PURPOSE
// - Upstream front end of the n_clic: takes asynchronous external interrupt lines, synchronises and
//   glitch-filters them, and turns each into a pend request held until the n_clic acknowledges it.
// - n_clic raises pend_ack[k] in the cycle it ORs the pend bit into its entry CSR for vector k.
// - Per-line edge or level mode; sticky overrun flag records rising edges lost while a request was open.
// PARAMETERS
// - IrqNum        8  number of external lines; line k feeds n_clic vector k+1 (vector 0 = timer)
// - SyncStages    2  flip-flops in each synchroniser chain; legal range >= 2
// - FilterCycles  0  consecutive cycles a synchronised change must hold to be accepted; 0 = filter bypassed
// PORTS
// - clk            in   1        core clock
// - reset          in   1        asynchronous, active-high reset
// - irq_in         in   IrqNum   asynchronous external interrupt lines, active-high
// - edge_mode      in   IrqNum   per line: 1 = rising-edge triggered, 0 = level triggered
// - pend_ack       in   IrqNum   n_clic has latched the pend bit of line k this cycle
// - overrun_clear  in   IrqNum   clear the sticky overrun flag of line k
// - pend_req       out  IrqNum   line k requests pend of its n_clic entry
// - overrun        out  IrqNum   sticky: an edge arrived while line k's edge request was still open
// - level_out      out  IrqNum   filtered line level (debug / CSR readback)
// BEHAVIOUR
// - Reset (async, asserts immediately): sync chains, filter counters, level_out, pend_req, overrun
//   and the previous-level register all 0.
// - Sync chain: irq_in[k] passes SyncStages registers; sync[k] = last stage.
// - Filter, FilterCycles = 0: level_out[k] = sync[k] combinationally, no counter.
// - Filter, FilterCycles > 0: per-line counter, width $clog2(FilterCycles+1).
//   - sync == level_out: counter -> 0.
//   - Else counter increments; on the edge where it would reach FilterCycles, level_out toggles, counter -> 0.
//   - Pulses shorter than FilterCycles cycles after sync are dropped; counter saturates, never wraps.
// - Event: rise[k] = level_out[k] & ~prev[k]; prev registered each cycle.
//   - prev resets to 0, so a line already high out of reset yields one rising event.
// - Edge mode: per-line FSM IDLE / PEND; pend_req = (state == PEND).
//   - IDLE: rise -> PEND.
//   - PEND: pend_ack & ~rise -> IDLE.
//   - PEND: rise & pend_ack -> stays PEND; the new edge is a fresh request, no overrun.
//   - PEND: rise & ~pend_ack -> stays PEND, overrun <= 1.
//   - pend_ack in IDLE: ignored.
// - Level mode: pend_req = registered level_out; pend_ack and overrun logic inactive; FSM held in IDLE.
// - Mode change (edge_mode[k] differs from last cycle): FSM -> IDLE, pend_req drops next cycle;
//   overrun kept.
// - overrun_clear & a new overrun in the same cycle: set wins.
// - Latency, stable input rising between edges: pend_req high on clock edge SyncStages+FilterCycles+1
//   counted from the first edge sampling irq_in high (edge mode and level mode alike).
// - Lines fully independent; any number may request or be acked in the same cycle.
// - reset mid-request: request lost, overrun cleared; lines still high re-trigger after latency.
// TESTING
// - Defaults, edge mode, irq_in[2] 0->1 held -> pend_req[2] rises on edge 3; ack edge 5 -> low edge 6, overrun 0.
// - FilterCycles=3: 2-cycle pulse on irq_in[0] -> no pend_req;
//   5-cycle pulse -> pend_req[0] on edge 6 (2+3+1).
// - Edge mode, 2nd rising edge on line 1 before ack -> overrun[1]=1, pend_req[1] stays 1;
//   overrun_clear same cycle as a new overrun -> overrun stays 1.
// - rise and pend_ack same cycle on line 4 -> pend_req[4] stays 1, overrun[4]=0.
// - Level mode line 3: irq high 10 cycles -> pend_req[3] high edges 3..12, ack ignored;
//   switch to edge mode while high -> pend_req low, no new event.
// - irq_in all ones through reset release -> every pend_req rises on edge 3 after release;
//   reset asserted mid-request -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/n_clic_ext_irq_if.sv
// Signal bundle between the external-interrupt front end and whatever drives/consumes it.
// The master side owns the raw lines, mode bits and acknowledges; the slave side is the front end.
interface n_clic_ext_irq_if #(
  parameter int IrqNum = 8
);
  logic [IrqNum-1:0] irq_in;
  logic [IrqNum-1:0] edge_mode;
  logic [IrqNum-1:0] pend_ack;
  logic [IrqNum-1:0] overrun_clear;
  logic [IrqNum-1:0] pend_req;
  logic [IrqNum-1:0] overrun;
  logic [IrqNum-1:0] level_out;

  modport master (
    output irq_in, edge_mode, pend_ack, overrun_clear,
    input  pend_req, overrun, level_out
  );

  modport slave (
    input  irq_in, edge_mode, pend_ack, overrun_clear,
    output pend_req, overrun, level_out
  );
endinterface

// File: rtl/n_clic_ext_irq.sv
// External interrupt front end for the n_clic: synchronise, glitch-filter and detect each line,
// then hold a pend request (edge mode) or mirror the level (level mode) until acknowledged.
module n_clic_ext_irq #(
  parameter int IrqNum       = 8,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 0
) (
  input  logic              clk,
  input  logic              reset,
  n_clic_ext_irq_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  logic [IrqNum-1:0] sync_q [SyncStages];
  logic [IrqNum-1:0] sync_d [SyncStages];
  logic [IrqNum-1:0] sync;
  logic [IrqNum-1:0] level;
  logic [IrqNum-1:0] rise;

  always_comb begin
    sync_d[0] = bus.irq_in;
    for (int s = 1; s < SyncStages; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
    end else begin
      for (int s = 0; s < SyncStages; s++) sync_q[s] <= sync_d[s];
    end
  end

  assign sync = sync_q[SyncStages-1];

  generate
    if (FilterCycles == 0) begin : g_nofilt
      assign level = sync;
    end else begin : g_filt
      localparam int CW = $clog2(FilterCycles + 1);
      logic [CW-1:0]     cnt_q [IrqNum];
      logic [CW-1:0]     cnt_d [IrqNum];
      logic [IrqNum-1:0] lvl_q, lvl_d;

      // Toggle on the cycle the count would reach FilterCycles, so it never exceeds FilterCycles-1.
      always_comb begin
        lvl_d = lvl_q;
        for (int k = 0; k < IrqNum; k++) begin
          cnt_d[k] = '0;
          if (sync[k] != lvl_q[k]) begin
            if (cnt_q[k] == CW'(FilterCycles - 1)) lvl_d[k] = ~lvl_q[k];
            else                                   cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lvl_q <= '0;
          for (int k = 0; k < IrqNum; k++) cnt_q[k] <= '0;
        end else begin
          lvl_q <= lvl_d;
          for (int k = 0; k < IrqNum; k++) cnt_q[k] <= cnt_d[k];
        end
      end

      assign level = lvl_q;
    end
  endgenerate

  state_t            state_q [IrqNum];
  state_t            state_d [IrqNum];
  logic [IrqNum-1:0] prev_q, prev_d;
  logic [IrqNum-1:0] mode_q, mode_d;
  logic [IrqNum-1:0] pend_q, pend_d;
  logic [IrqNum-1:0] ovr_q, ovr_d;
  logic [IrqNum-1:0] ovr_set;

  assign rise = level & ~prev_q;

  always_comb begin
    prev_d  = level;
    mode_d  = bus.edge_mode;
    pend_d  = '0;
    ovr_set = '0;
    for (int k = 0; k < IrqNum; k++) begin
      state_d[k] = state_q[k];
      if (bus.edge_mode[k] != mode_q[k]) begin
        state_d[k] = IDLE;
      end else if (bus.edge_mode[k]) begin
        case (state_q[k])
          IDLE: if (rise[k]) state_d[k] = PEND;
          PEND: begin
            // An edge arriving together with the ack is a fresh request, not a lost one.
            if (rise[k] && !bus.pend_ack[k])      ovr_set[k] = 1'b1;
            else if (bus.pend_ack[k] && !rise[k]) state_d[k] = IDLE;
          end
          default: state_d[k] = IDLE;
        endcase
        pend_d[k] = (state_d[k] == PEND);
      end else begin
        state_d[k] = IDLE;
        pend_d[k]  = level[k];
      end
    end
    ovr_d = ovr_set | (ovr_q & ~bus.overrun_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      for (int k = 0; k < IrqNum; k++) state_q[k] <= IDLE;
    end else begin
      prev_q <= prev_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      for (int k = 0; k < IrqNum; k++) state_q[k] <= state_d[k];
    end
  end

  assign bus.pend_req  = pend_q;
  assign bus.overrun   = ovr_q;
  assign bus.level_out = level;

endmodule

// File: tb/tb_n_clic_ext_irq.sv
// Directed bench for n_clic_ext_irq: one unfiltered instance (b0/u0) and one with FilterCycles=3 (b1/u1).
module tb_n_clic_ext_irq;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  n_clic_ext_irq_if #(.IrqNum(8)) b0 ();
  n_clic_ext_irq_if #(.IrqNum(8)) b1 ();

  n_clic_ext_irq #(.IrqNum(8), .SyncStages(2), .FilterCycles(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );
  n_clic_ext_irq #(.IrqNum(8), .SyncStages(2), .FilterCycles(3)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b0.irq_in = 8'hFF; b1.irq_in = 8'hFF;
    b0.edge_mode = 8'hFF; b1.edge_mode = 8'hFF;
    b0.pend_ack = '0; b1.pend_ack = '0;
    b0.overrun_clear = '0; b1.overrun_clear = '0;
    tick(4);
    total++; if (b0.pend_req !== 8'h00) begin bad++; $display("FAIL reset_pend0 got=%h exp=00", b0.pend_req); end
    total++; if (b0.overrun !== 8'h00) begin bad++; $display("FAIL reset_ovr0 got=%h exp=00", b0.overrun); end
    total++; if (b0.level_out !== 8'h00) begin bad++; $display("FAIL reset_lvl0 got=%h exp=00", b0.level_out); end
    total++; if (b1.pend_req !== 8'h00) begin bad++; $display("FAIL reset_pend1 got=%h exp=00", b1.pend_req); end
    total++; if (b1.level_out !== 8'h00) begin bad++; $display("FAIL reset_lvl1 got=%h exp=00", b1.level_out); end
    b0.irq_in = '0; b1.irq_in = '0;
    tick(1);
    reset = 1'b0;
    tick(6);
    $display("test_reset: outputs held at zero under reset");
  endtask

  task automatic test_edge_basic();
    b0.irq_in[2] = 1'b1;
    tick(2);
    total++; if (b0.pend_req[2] !== 1'b0) begin bad++; $display("FAIL edge_e2 got=%b exp=0", b0.pend_req[2]); end
    total++; if (b0.level_out[2] !== 1'b1) begin bad++; $display("FAIL edge_lvl_e2 got=%b exp=1", b0.level_out[2]); end
    tick(1);
    total++; if (b0.pend_req !== 8'h04) begin bad++; $display("FAIL edge_e3 got=%h exp=04", b0.pend_req); end
    tick(2);
    total++; if (b0.pend_req[2] !== 1'b1) begin bad++; $display("FAIL edge_hold_e5 got=%b exp=1", b0.pend_req[2]); end
    b0.pend_ack[2] = 1'b1;
    tick(1);
    b0.pend_ack[2] = 1'b0;
    total++; if (b0.pend_req[2] !== 1'b0) begin bad++; $display("FAIL edge_ack_e6 got=%b exp=0", b0.pend_req[2]); end
    total++; if (b0.overrun[2] !== 1'b0) begin bad++; $display("FAIL edge_ovr got=%b exp=0", b0.overrun[2]); end
    tick(2);
    total++; if (b0.pend_req[2] !== 1'b0) begin bad++; $display("FAIL edge_no_retrig got=%b exp=0", b0.pend_req[2]); end
    b0.irq_in[2] = 1'b0;
    tick(4);
    $display("test_edge_basic: line 2 request and ack");
  endtask

  task automatic test_filter();
    b1.irq_in[0] = 1'b1;
    tick(2);
    b1.irq_in[0] = 1'b0;
    tick(10);
    total++; if (b1.pend_req[0] !== 1'b0) begin bad++; $display("FAIL filt_short_pend got=%b exp=0", b1.pend_req[0]); end
    total++; if (b1.level_out[0] !== 1'b0) begin bad++; $display("FAIL filt_short_lvl got=%b exp=0", b1.level_out[0]); end
    b1.irq_in[0] = 1'b1;
    tick(4);
    total++; if (b1.level_out[0] !== 1'b0) begin bad++; $display("FAIL filt_lvl_e4 got=%b exp=0", b1.level_out[0]); end
    tick(1);
    b1.irq_in[0] = 1'b0;
    total++; if (b1.level_out[0] !== 1'b1) begin bad++; $display("FAIL filt_lvl_e5 got=%b exp=1", b1.level_out[0]); end
    total++; if (b1.pend_req[0] !== 1'b0) begin bad++; $display("FAIL filt_pend_e5 got=%b exp=0", b1.pend_req[0]); end
    tick(1);
    total++; if (b1.pend_req !== 8'h01) begin bad++; $display("FAIL filt_pend_e6 got=%h exp=01", b1.pend_req); end
    b1.pend_ack[0] = 1'b1;
    tick(1);
    b1.pend_ack[0] = 1'b0;
    total++; if (b1.pend_req[0] !== 1'b0) begin bad++; $display("FAIL filt_ack got=%b exp=0", b1.pend_req[0]); end
    tick(8);
    total++; if (b1.level_out[0] !== 1'b0) begin bad++; $display("FAIL filt_fall got=%b exp=0", b1.level_out[0]); end
    $display("test_filter: short pulse dropped, long pulse accepted");
  endtask

  task automatic test_overrun();
    b0.irq_in[1] = 1'b1;
    tick(3);
    total++; if (b0.pend_req[1] !== 1'b1) begin bad++; $display("FAIL ovr_first got=%b exp=1", b0.pend_req[1]); end
    b0.irq_in[1] = 1'b0;
    tick(3);
    b0.irq_in[1] = 1'b1;
    tick(3);
    total++; if (b0.overrun !== 8'h02) begin bad++; $display("FAIL ovr_set got=%h exp=02", b0.overrun); end
    total++; if (b0.pend_req[1] !== 1'b1) begin bad++; $display("FAIL ovr_pend got=%b exp=1", b0.pend_req[1]); end
    b0.overrun_clear[1] = 1'b1;
    tick(1);
    b0.overrun_clear[1] = 1'b0;
    total++; if (b0.overrun[1] !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", b0.overrun[1]); end
    b0.irq_in[1] = 1'b0;
    tick(3);
    b0.irq_in[1] = 1'b1;
    tick(2);
    b0.overrun_clear[1] = 1'b1;
    tick(1);
    b0.overrun_clear[1] = 1'b0;
    total++; if (b0.overrun[1] !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", b0.overrun[1]); end
    b0.pend_ack[1] = 1'b1;
    tick(1);
    b0.pend_ack[1] = 1'b0;
    total++; if (b0.pend_req[1] !== 1'b0) begin bad++; $display("FAIL ovr_ack got=%b exp=0", b0.pend_req[1]); end
    b0.irq_in[1] = 1'b0;
    b0.overrun_clear[1] = 1'b1;
    tick(1);
    b0.overrun_clear[1] = 1'b0;
    tick(3);
    $display("test_overrun: line 1 sticky overrun");
  endtask

  task automatic test_rise_ack();
    b0.irq_in[4] = 1'b1;
    tick(3);
    b0.irq_in[4] = 1'b0;
    tick(3);
    b0.irq_in[4] = 1'b1;
    tick(2);
    b0.pend_ack[4] = 1'b1;
    tick(1);
    b0.pend_ack[4] = 1'b0;
    total++; if (b0.pend_req[4] !== 1'b1) begin bad++; $display("FAIL riseack_pend got=%b exp=1", b0.pend_req[4]); end
    total++; if (b0.overrun[4] !== 1'b0) begin bad++; $display("FAIL riseack_ovr got=%b exp=0", b0.overrun[4]); end
    b0.pend_ack[4] = 1'b1;
    tick(1);
    b0.pend_ack[4] = 1'b0;
    total++; if (b0.pend_req[4] !== 1'b0) begin bad++; $display("FAIL riseack_ack2 got=%b exp=0", b0.pend_req[4]); end
    b0.irq_in[4] = 1'b0;
    tick(3);
    $display("test_rise_ack: line 4 edge with ack is a fresh request");
  endtask

  task automatic test_level();
    logic exp_p;
    b0.edge_mode[3] = 1'b0;
    tick(3);
    b0.irq_in[3] = 1'b1;
    b0.pend_ack[3] = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick(1);
      exp_p = (e >= 3 && e <= 12);
      total++; if (b0.pend_req[3] !== exp_p) begin bad++; $display("FAIL level_e%0d got=%b exp=%b", e, b0.pend_req[3], exp_p); end
      if (e == 10) b0.irq_in[3] = 1'b0;
    end
    b0.pend_ack[3] = 1'b0;
    tick(2);
    b0.irq_in[3] = 1'b1;
    tick(3);
    total++; if (b0.pend_req[3] !== 1'b1) begin bad++; $display("FAIL level_high got=%b exp=1", b0.pend_req[3]); end
    b0.edge_mode[3] = 1'b1;
    tick(1);
    total++; if (b0.pend_req[3] !== 1'b0) begin bad++; $display("FAIL level_switch got=%b exp=0", b0.pend_req[3]); end
    tick(3);
    total++; if (b0.pend_req !== 8'h00) begin bad++; $display("FAIL level_no_event got=%h exp=00", b0.pend_req); end
    b0.irq_in[3] = 1'b0;
    tick(3);
    $display("test_level: line 3 level mode and mode switch");
  endtask

  task automatic test_reset_all();
    reset = 1'b1;
    b0.irq_in = 8'hFF; b1.irq_in = 8'hFF;
    tick(2);
    reset = 1'b0;
    tick(2);
    total++; if (b0.pend_req !== 8'h00) begin bad++; $display("FAIL rel_e2 got=%h exp=00", b0.pend_req); end
    tick(1);
    total++; if (b0.pend_req !== 8'hFF) begin bad++; $display("FAIL rel_e3 got=%h exp=ff", b0.pend_req); end
    total++; if (b1.pend_req !== 8'h00) begin bad++; $display("FAIL rel_f_e3 got=%h exp=00", b1.pend_req); end
    tick(3);
    total++; if (b1.pend_req !== 8'hFF) begin bad++; $display("FAIL rel_f_e6 got=%h exp=ff", b1.pend_req); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (b0.pend_req !== 8'h00) begin bad++; $display("FAIL async_pend0 got=%h exp=00", b0.pend_req); end
    total++; if (b0.level_out !== 8'h00) begin bad++; $display("FAIL async_lvl0 got=%h exp=00", b0.level_out); end
    total++; if (b1.pend_req !== 8'h00) begin bad++; $display("FAIL async_pend1 got=%h exp=00", b1.pend_req); end
    total++; if (b1.level_out !== 8'h00) begin bad++; $display("FAIL async_lvl1 got=%h exp=00", b1.level_out); end
    tick(1);
    reset = 1'b0;
    $display("test_reset_all: all lines through reset release and async reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_edge_basic();
    test_filter();
    test_overrun();
    test_rise_ack();
    test_level();
    test_reset_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
